// File: rtl/gear_input_conditioner_if.sv
// Button and request signals between the raw gearbox controls and the gear_input_conditioner.
// Carries the tick strobe, raw buttons and the conditioned request/level outputs.
interface gear_input_conditioner_if;
  logic tick;
  logic shift_up;
  logic shift_down;
  logic brake;
  logic shift_up_req;
  logic shift_down_req;
  logic brake_level;

  modport master (
    output tick, shift_up, shift_down, brake,
    input  shift_up_req, shift_down_req, brake_level
  );

  modport slave (
    input  tick, shift_up, shift_down, brake,
    output shift_up_req, shift_down_req, brake_level
  );
endinterface

// File: rtl/gear_input_conditioner.sv
// Synchronises and debounces the gearbox buttons into sticky shift requests and a brake level.
// Optional auto-repeat of held shift buttons is enabled by defining GEAR_AUTOREPEAT_EN.
module gear_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_CYCLES   = 25_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned RPT_W           = 25
) (
  input logic                     clk,
  input logic                     reset,
  gear_input_conditioner_if.slave bus
);

  localparam int unsigned NBtn   = 3;
  localparam int unsigned IdxUp  = 0;
  localparam int unsigned IdxDn  = 1;
  localparam int unsigned IdxBrk = 2;

  // Elaboration-time guard on the counter ranges; the counters must clear before they wrap.
  if (64'(DEBOUNCE_CYCLES) < 64'd2 || 64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))
  begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (64'(REPEAT_CYCLES) < 64'd2 || 64'(REPEAT_CYCLES) > ((64'd1 << RPT_W) - 64'd1))
  begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range for RPT_W");
  end

  logic [NBtn-1:0]            sync1_q, sync1_d;
  logic [NBtn-1:0]            sync2_q, sync2_d;
  logic [NBtn-1:0]            stable_q, stable_d;
  logic [NBtn-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       up_req_q, up_req_d;
  logic                       dn_req_q, dn_req_d;
  logic [NBtn-1:0]            rise_c;
  logic                       brake_block_c;
  logic [1:0]                 rpt_ev_c;
  logic                       up_ev_c, dn_ev_c;

  // Two-flop synchroniser plus per-button debounce counter.
  always_comb begin
    sync1_d  = {bus.brake, bus.shift_down, bus.shift_up};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < int'(NBtn); i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising events are taken from the next stable value so the flag sets on the same edge.
  assign rise_c        = stable_d & ~stable_q;
  assign brake_block_c = stable_q[IdxBrk] | stable_d[IdxBrk];

`ifdef GEAR_AUTOREPEAT_EN
  logic [1:0][RPT_W-1:0] rpt_q, rpt_d;

  // Held shift buttons re-fire every REPEAT_CYCLES while brake is released.
  always_comb begin
    rpt_d    = '0;
    rpt_ev_c = '0;
    for (int i = 0; i < 2; i++) begin
      if (stable_q[i] && !brake_block_c) begin
        if (rpt_q[i] == RPT_W'(REPEAT_CYCLES - 1)) begin
          rpt_ev_c[i] = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign rpt_ev_c = '0;
`endif

  // Sticky request flags: brake dominates, simultaneous directions cancel, latest direction wins.
  always_comb begin
    up_ev_c = rise_c[IdxUp] | rpt_ev_c[IdxUp];
    dn_ev_c = rise_c[IdxDn] | rpt_ev_c[IdxDn];
    if (up_ev_c && dn_ev_c) begin
      up_ev_c = 1'b0;
      dn_ev_c = 1'b0;
    end
    up_req_d = up_ev_c | (up_req_q & ~bus.tick & ~dn_ev_c);
    dn_req_d = dn_ev_c | (dn_req_q & ~bus.tick & ~up_ev_c);
    if (brake_block_c) begin
      up_req_d = 1'b0;
      dn_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      up_req_q <= 1'b0;
      dn_req_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      up_req_q <= up_req_d;
      dn_req_q <= dn_req_d;
    end
  end

  assign bus.shift_up_req   = up_req_q;
  assign bus.shift_down_req = dn_req_q;
  assign bus.brake_level    = stable_q[IdxBrk];

endmodule
